// File: rtl/lockstep_checker.sv
// Compares the register-file writeback ports of two lockstep cores through a
// two-stage pipeline and reports the first divergence of each recovery episode.
module lockstep_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_a_i,
  input  logic [ADDR_WIDTH-1:0]  waddr_a_i,
  input  logic [DATA_WIDTH-1:0]  wdata_a_i,
  input  logic                   we_b_i,
  input  logic [ADDR_WIDTH-1:0]  waddr_b_i,
  input  logic [DATA_WIDTH-1:0]  wdata_b_i,
  input  logic                   resume_i,
  input  logic                   clear_i,
  output logic                   error_o,
  output logic                   armed_o,
  output logic                   err_valid_o,
  output logic [ADDR_WIDTH-1:0]  err_addr_o,
  output logic [COUNT_WIDTH-1:0] err_count_o
);

  typedef enum logic {MONITOR = 1'b0, BLOCKED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic                   we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0]  waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0]  wdata_a_q, wdata_b_q;
  logic [1:0]             vld_q, vld_d;
  logic                   s2_mis_q;
  logic [ADDR_WIDTH-1:0]  s2_addr_q;
  logic                   s1_mis;
  logic                   report;
  logic                   error_q, error_d;
  logic                   err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, count_base;

  // Address/data only matter when both cores actually write.
  assign s1_mis = (we_a_q != we_b_q) ||
                  (we_a_q && we_b_q && ((waddr_a_q != waddr_b_q) || (wdata_a_q != wdata_b_q)));

  always_comb begin
    state_d = state_q;
    report  = 1'b0;
    case (state_q)
      MONITOR: begin
        if (vld_q[1] && s2_mis_q) begin
          report  = 1'b1;
          state_d = BLOCKED;
        end
      end
      BLOCKED: begin
        if (resume_i) state_d = MONITOR;
      end
      default: state_d = MONITOR;
    endcase
  end

  // Valids only survive into a cycle that will be spent in MONITOR, so
  // anything sampled while blocked (or at the blocking edge) is dropped.
  always_comb begin
    vld_d[0] = (state_d == MONITOR);
    vld_d[1] = vld_q[0] && (state_d == MONITOR);
  end

  always_comb begin
    count_base  = clear_i ? '0 : count_q;
    err_valid_d = clear_i ? 1'b0 : err_valid_q;
    err_addr_d  = clear_i ? '0 : err_addr_q;
    count_d     = count_base;
    error_d     = report;
    if (report) begin
      err_valid_d = 1'b1;
      err_addr_d  = s2_addr_q;
      if (!(&count_base)) count_d = count_base + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= MONITOR;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      waddr_a_q   <= '0;
      waddr_b_q   <= '0;
      wdata_a_q   <= '0;
      wdata_b_q   <= '0;
      vld_q       <= '0;
      s2_mis_q    <= 1'b0;
      s2_addr_q   <= '0;
      error_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_a_q      <= we_a_i;
      we_b_q      <= we_b_i;
      waddr_a_q   <= waddr_a_i;
      waddr_b_q   <= waddr_b_i;
      wdata_a_q   <= wdata_a_i;
      wdata_b_q   <= wdata_b_i;
      vld_q       <= vld_d;
      s2_mis_q    <= s1_mis;
      s2_addr_q   <= waddr_a_q;
      error_q     <= error_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      count_q     <= count_d;
    end
  end

  assign error_o     = error_q;
  assign armed_o     = (state_q == MONITOR);
  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_count_o = count_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: stimulus pushes expected error reports,
// a negedge monitor pops and compares them whenever error_o is seen.
module tb_lockstep_checker;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_a, we_b, resume, clear;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          error_o, armed_o, err_valid_o;
  logic [AW-1:0] err_addr_o;
  logic [CW-1:0] err_count_o;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  lockstep_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .we_a_i(we_a), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a),
    .we_b_i(we_b), .waddr_b_i(waddr_b), .wdata_b_i(wdata_b),
    .resume_i(resume), .clear_i(clear),
    .error_o(error_o), .armed_o(armed_o), .err_valid_o(err_valid_o),
    .err_addr_o(err_addr_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: each observed pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (error_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_addr", int'(err_addr_o), int'(e.addr));
        chk("pulse_count", int'(err_count_o), int'(e.cnt));
        chk("pulse_valid", int'(err_valid_o), 1);
        chk("pulse_armed", int'(armed_o), 0);
      end
    end
  end

  // Drive one cycle of taps; they are sampled at the next posedge.
  task automatic tap(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                     input logic res = 1'b0, input logic clr = 1'b0);
    @(negedge clk);
    we_a = wa; waddr_a = aa; wdata_a = da;
    we_b = wb; waddr_b = ab; wdata_b = db;
    resume = res; clear = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tap(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Data mismatch at addr a; optionally expect a report with count c.
  task automatic mism(input logic [AW-1:0] a, input logic expect_it, input logic [CW-1:0] c,
                      input logic res = 1'b0);
    exp_t e;
    tap(1'b1, a, 32'h1234, 1'b1, a, 32'h1235, res);
    if (expect_it) begin
      e.cyc = cyc + 3; e.addr = a; e.cnt = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_error"}, int'(error_o), 0);
    chk({tag, "_armed"}, int'(armed_o), 1);
    chk({tag, "_valid"}, int'(err_valid_o), 0);
    chk({tag, "_addr"}, int'(err_addr_o), 0);
    chk({tag, "_count"}, int'(err_count_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    we_a = 0; we_b = 0; waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
    resume = 0; clear = 0;
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Matched random traffic
    for (int i = 0; i < 100; i++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      w = 1'($urandom_range(0, 1)); a = AW'($urandom); d = $urandom;
      tap(w, a, d, w, a, d);
    end
    idle(3);
    chk("matched_count", int'(err_count_o), 0);
    chk("matched_armed", int'(armed_o), 1);

    // Data mismatch at addr 7
    mism(5'd7, 1'b1, 2'd1);
    idle(4);
    chk("blocked_armed", int'(armed_o), 0);

    // Blocked mismatches, then resume together with a new mismatch
    for (int i = 0; i < 5; i++) mism(AW'(9 + i), 1'b0, '0);
    idle(3);
    chk("blocked_count", int'(err_count_o), 1);
    chk("blocked_addr", int'(err_addr_o), 7);
    mism(5'd12, 1'b1, 2'd2, 1'b1);
    idle(5);

    // Enable-only mismatch
    tap(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    begin
      exp_t e;
      tap(1'b1, 5'd3, 32'h5, 1'b0, '0, '0);
      e.cyc = cyc + 3; e.addr = 5'd3; e.cnt = 2'd3;
      exp_q.push_back(e);
    end
    idle(5);

    // Both enables low: address/data differences are ignored
    tap(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    tap(1'b0, 5'd1, 32'hAA, 1'b0, 5'd2, 32'hBB);
    tap(1'b0, 5'd4, 32'h1, 1'b0, 5'd5, 32'h2);
    idle(5);
    chk("dontcare_armed", int'(armed_o), 1);

    // Saturation: two more episodes, count holds at 3
    for (int i = 0; i < 2; i++) begin
      mism(AW'(20 + i), 1'b1, 2'd3);
      idle(5);
      tap(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    end
    chk("sat_count", int'(err_count_o), 3);

    // Clear at the same edge as a 6th report: report wins
    mism(5'd25, 1'b1, 2'd1);
    idle(1);
    tap(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(3);
    chk("clr_race_count", int'(err_count_o), 1);
    chk("clr_race_valid", int'(err_valid_o), 1);
    chk("clr_race_addr", int'(err_addr_o), 25);

    // Plain clear leaves state alone
    tap(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);
    chk("clear_count", int'(err_count_o), 0);
    chk("clear_valid", int'(err_valid_o), 0);
    chk("clear_addr", int'(err_addr_o), 0);
    chk("clear_armed", int'(armed_o), 0);

    // Async reset in the middle of a pulse (monitor never sees this pulse)
    tap(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    mism(5'd30, 1'b0, '0);
    idle(2);
    @(posedge clk); #1;
    chk("pre_rst_pulse", int'(error_o), 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    mism(5'd17, 1'b1, 2'd1);
    idle(6);

    chk("pending_reports", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
